// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the FIFO write and read controllers.
// Pointers are carried as {wrap, addr} packed into an int-sized container.
package fifo_pkg;

    typedef int unsigned ptr_word_t;

    // Width of a {wrap, addr} pointer for a given RAM address width.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_word_t ptr_addr(input ptr_word_t ptr, input int addr_width);
        return ptr & ((ptr_word_t'(1) << addr_width) - ptr_word_t'(1));
    endfunction

    function automatic ptr_word_t ptr_wrap(input ptr_word_t ptr, input int addr_width);
        return (ptr >> addr_width) & ptr_word_t'(1);
    endfunction

    // Advance by one entry; the address stays below depth and the wrap bit toggles on rollover.
    function automatic ptr_word_t ptr_next(input ptr_word_t ptr, input int addr_width,
                                           input int depth);
        ptr_word_t addr;
        ptr_word_t wrap;
        addr = ptr_addr(ptr, addr_width);
        wrap = ptr_wrap(ptr, addr_width);
        if (addr == ptr_word_t'(depth - 1)) begin
            addr = 0;
            wrap = wrap ^ ptr_word_t'(1);
        end else begin
            addr = addr + 1;
        end
        return (wrap << addr_width) | addr;
    endfunction

    function automatic ptr_word_t ptr_count(input ptr_word_t wptr, input ptr_word_t rptr,
                                            input int addr_width, input int depth);
        ptr_word_t waddr;
        ptr_word_t raddr;
        waddr = ptr_addr(wptr, addr_width);
        raddr = ptr_addr(rptr, addr_width);
        if (ptr_wrap(wptr, addr_width) == ptr_wrap(rptr, addr_width))
            return waddr - raddr;
        else
            return ptr_word_t'(depth) - raddr + waddr;
    endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Producer-side bus of the FIFO write controller.
// write is a request; fifo_write is its same-cycle acceptance (no ready/valid buffering).
interface fifo_write_ctrl_if #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DROP_CNT_WIDTH = 8
);
    logic                      write;
    logic                      flush;
    logic [ADDR_WIDTH:0]       rptr;
    logic                      fifo_write;
    logic [ADDR_WIDTH-1:0]     waddr;
    logic [ADDR_WIDTH:0]       wptr;
    logic [ADDR_WIDTH:0]       count;
    logic                      fifo_full;
    logic                      almost_full;
    logic                      overflow;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    modport master (
        output write, flush, rptr,
        input  fifo_write, waddr, wptr, count, fifo_full, almost_full, overflow, drop_cnt
    );

    modport slave (
        input  write, flush, rptr,
        output fifo_write, waddr, wptr, count, fifo_full, almost_full, overflow, drop_cnt
    );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/status controller: accepts writes while not full, tracks occupancy
// against the read pointer, and records rejected writes in a sticky flag and saturating counter.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DEPTH          = 32,
    parameter int AFULL_LEVEL    = DEPTH - 2,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    fifo_write_ctrl_if.slave bus
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LEVEL);

    logic [PW-1:0]             wptr_q;
    logic                      overflow_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    logic [PW-1:0]             wptr_nxt;
    logic [PW-1:0]             count;
    logic                      full;
    logic                      accept;
    logic                      reject;

    always_comb begin
        wptr_nxt = PW'(ptr_next(ptr_word_t'(wptr_q), ADDR_WIDTH, DEPTH));
        count    = PW'(ptr_count(ptr_word_t'(wptr_q), ptr_word_t'(bus.rptr), ADDR_WIDTH, DEPTH));
    end

    // Full is judged on the current read pointer only; a same-cycle pop does not make room.
    assign full   = (wptr_q[ADDR_WIDTH-1:0] == bus.rptr[ADDR_WIDTH-1:0]) &&
                    (wptr_q[ADDR_WIDTH] != bus.rptr[ADDR_WIDTH]);
    assign accept = bus.write & ~full & ~bus.flush & ~reset;
    assign reject = bus.write & full & ~bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (bus.flush) begin
            wptr_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (accept)
                wptr_q <= wptr_nxt;
            if (reject) begin
                overflow_q <= 1'b1;
                if (drop_q != '1)
                    drop_q <= drop_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign bus.fifo_write  = accept;
    assign bus.waddr       = wptr_q[ADDR_WIDTH-1:0];
    assign bus.wptr        = wptr_q;
    assign bus.count       = count;
    assign bus.fifo_full   = full;
    assign bus.almost_full = (count >= AFULL_C);
    assign bus.overflow    = overflow_q;
    assign bus.drop_cnt    = drop_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (int'(bus.rptr[ADDR_WIDTH-1:0]) < DEPTH)
                else $error("rptr address %0d out of range", bus.rptr[ADDR_WIDTH-1:0]);
            assert (count <= DEPTH_C)
                else $error("occupancy %0d exceeds depth", count);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with DEPTH=5 (non-power-of-two) and a 2-bit drop counter.
module tb_fifo_write_ctrl;

    localparam int AW  = 3;
    localparam int DEP = 5;
    localparam int AFL = 4;
    localparam int DCW = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fifo_write_ctrl_if #(.ADDR_WIDTH(AW), .DROP_CNT_WIDTH(DCW)) bus ();

    fifo_write_ctrl #(
        .ADDR_WIDTH(AW), .DEPTH(DEP), .AFULL_LEVEL(AFL), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.write = 1'b1;
        bus.flush = 1'b0;
        bus.rptr  = '0;

        // Reset state, with write held high to show the enable is gated.
        repeat (2) tick();
        check("rst_wptr",     32'(bus.wptr), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_drop",     32'(bus.drop_cnt), 0);
        check("rst_count",    32'(bus.count), 0);
        check("rst_full",     32'(bus.fifo_full), 0);
        check("rst_afull",    32'(bus.almost_full), 0);
        check("rst_fwrite",   32'(bus.fifo_write), 0);
        bus.write = 1'b0;
        reset     = 1'b0;
        tick();
        check("rel_wptr", 32'(bus.wptr), 0);

        // Fill from empty: five accepted writes.
        bus.write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("fill_fwrite", 32'(bus.fifo_write), 1);
            check("fill_waddr",  32'(bus.waddr), i);
            check("fill_count",  32'(bus.count), i);
            check("fill_afull",  32'(bus.almost_full), (i >= 4) ? 1 : 0);
            check("fill_full",   32'(bus.fifo_full), 0);
            tick();
        end
        check("full_wptr",   32'(bus.wptr), 8);
        check("full_count",  32'(bus.count), 5);
        check("full_full",   32'(bus.fifo_full), 1);
        check("full_afull",  32'(bus.almost_full), 1);
        check("full_fwrite", 32'(bus.fifo_write), 0);

        // Three writes while full are dropped.
        for (int d = 1; d <= 3; d++) begin
            tick();
            check("ovf_flag", 32'(bus.overflow), 1);
            check("ovf_drop", 32'(bus.drop_cnt), d);
            check("ovf_wptr", 32'(bus.wptr), 8);
        end

        // Reader pops one: space opens and the next write lands at address 0.
        bus.rptr = 4'b0001;
        #1;
        check("pop_full",   32'(bus.fifo_full), 0);
        check("pop_count",  32'(bus.count), 4);
        check("pop_fwrite", 32'(bus.fifo_write), 1);
        check("pop_waddr",  32'(bus.waddr), 0);
        tick();
        check("pop_wptr", 32'(bus.wptr), 9);

        // Walk wptr to {1,3} with the reader caught up, then wrap through address 4.
        bus.write = 1'b0;
        bus.rptr  = 4'b1001;
        #1;
        check("catch_count", 32'(bus.count), 0);
        bus.write = 1'b1;
        tick();
        tick();
        check("walk_wptr", 32'(bus.wptr), 11);
        bus.write = 1'b0;
        bus.rptr  = 4'b1011;
        #1;
        bus.write = 1'b1;
        #1;
        check("wrap_waddr3", 32'(bus.waddr), 3);
        check("wrap_fw3",    32'(bus.fifo_write), 1);
        tick();
        check("wrap_waddr4", 32'(bus.waddr), 4);
        tick();
        check("wrap_wptr",  32'(bus.wptr), 0);
        check("wrap_count", 32'(bus.count), 2);

        // Fill again, then flush while full with overflow set.
        repeat (3) tick();
        check("refill_wptr", 32'(bus.wptr), 3);
        check("refill_full", 32'(bus.fifo_full), 1);
        check("refill_drop", 32'(bus.drop_cnt), 3);
        bus.flush = 1'b1;
        #1;
        check("flush_fwrite", 32'(bus.fifo_write), 0);
        tick();
        check("flush_wptr",     32'(bus.wptr), 0);
        check("flush_overflow", 32'(bus.overflow), 0);
        check("flush_drop",     32'(bus.drop_cnt), 0);
        bus.flush = 1'b0;
        bus.rptr  = '0;
        #1;
        check("flush_count", 32'(bus.count), 0);

        // Saturation: fill, then six rejected writes on a 2-bit counter.
        repeat (5) tick();
        check("sat_full", 32'(bus.fifo_full), 1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("sat_drop",     32'(bus.drop_cnt), (i > 3) ? 3 : i);
            check("sat_overflow", 32'(bus.overflow), 1);
        end
        check("sat_wptr", 32'(bus.wptr), 8);

        // Asynchronous reset in the middle of a write stream.
        bus.rptr = 4'b0010;
        #1;
        check("stream_fwrite", 32'(bus.fifo_write), 1);
        tick();
        check("stream_wptr", 32'(bus.wptr), 9);
        #3;
        reset    = 1'b1;
        bus.rptr = '0;
        #1;
        check("arst_wptr",     32'(bus.wptr), 0);
        check("arst_overflow", 32'(bus.overflow), 0);
        check("arst_drop",     32'(bus.drop_cnt), 0);
        check("arst_fwrite",   32'(bus.fifo_write), 0);
        tick();
        check("arst_hold_fwrite", 32'(bus.fifo_write), 0);
        check("arst_hold_wptr",   32'(bus.wptr), 0);
        reset = 1'b0;
        #1;
        check("post_fwrite", 32'(bus.fifo_write), 1);
        tick();
        check("post_wptr", 32'(bus.wptr), 1);
        bus.write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
